// File: rtl/dram_bank_scheduler.sv
// ---------------------------------------------------------------------------
// dram_bank_scheduler
//   Command scheduler for a single emulated DRAM bank. It takes one read or
//   write request at a time and turns it into ACT / PR / RD / WR (or RDA /
//   WRA) pulses that respect tRCD, tRP, tRAS and the burst length. By default
//   it uses an open-page policy: the row stays open and row hits skip the ACT.
//
//   Optional feature macro: CLOSE_PAGE_EN
//     defined   -> auto-precharge accesses (RDA/WRA) and the row closes after
//                  every burst, so each request starts with an ACT.
//     undefined -> open-page policy; RDA/WRA are tied low.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   halt                     freeze state/counters; command pulses and done forced low
//   req_valid/req_ready      request handshake
//   req_we/row/col/wdata     request fields, latched on acceptance
//   ACT PR RD WR RDA WRA     one-cycle command pulses
//   row, column, dq          address and write data for the bank
//   rd_req, wr_req           burst windows, TBURST cycles long
//   done                     pulse on the last burst cycle
//   row_open                 a row is currently open
// ---------------------------------------------------------------------------
module dram_bank_scheduler #(
    parameter int width   = 8,
    parameter int rows    = 128,
    parameter int columns = 64,
    parameter int TRCD    = 4,
    parameter int TRP     = 4,
    parameter int TRAS    = 10,
    parameter int TBURST  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       halt,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [$clog2(rows)-1:0]    req_row,
    input  logic [$clog2(columns)-1:0] req_col,
    input  logic [width-1:0]           req_wdata,
    output logic                       ACT,
    output logic                       PR,
    output logic                       RD,
    output logic                       WR,
    output logic                       RDA,
    output logic                       WRA,
    output logic [$clog2(rows)-1:0]    row,
    output logic [$clog2(columns)-1:0] column,
    output logic [width-1:0]           dq,
    output logic                       wr_req,
    output logic                       rd_req,
    output logic                       done,
    output logic                       row_open
);
    localparam int RW   = $clog2(rows);
    localparam int CW   = $clog2(columns);
    localparam int CNTW = 8;
    localparam int RASW = $clog2(TRAS + 1);

    typedef enum logic [2:0] {IDLE, WAIT_RCD, ACTIVE, BURST, WAIT_RAS, WAIT_RP} state_t;

    state_t            state_reg, state_next;
    logic [CNTW-1:0]   cnt_reg, cnt_next;     // shared by RCD / RP / burst waits
    logic [RASW-1:0]   ras_reg, ras_next;     // cycles since last ACT, saturating
    logic              act_reg, act_next;
    logic              pr_reg, pr_next;
    logic              rd_reg, rd_next;
    logic              wr_reg, wr_next;
    logic              rd_req_reg, rd_req_next;
    logic              wr_req_reg, wr_req_next;
    logic              open_reg, open_next;
    logic [RW-1:0]     row_reg, row_next;
    logic [CW-1:0]     column_reg, column_next;
    logic [width-1:0]  dq_reg, dq_next;
    logic              pend_we_reg, pend_we_next;
    logic [RW-1:0]     pend_row_reg, pend_row_next;
    logic [CW-1:0]     pend_col_reg, pend_col_next;
    logic [width-1:0]  pend_wdata_reg, pend_wdata_next;

    logic              accept, ras_ok, start_act, start_pre, start_burst;
    logic              acc_we;
    logic [RW-1:0]     acc_row;
    logic [CW-1:0]     acc_col;
    logic [width-1:0]  acc_wdata;

    assign req_ready = !halt && (state_reg == IDLE || state_reg == ACTIVE);
    assign accept    = req_valid && req_ready;
    // PR issues one edge after the decision, hence TRAS-1 here.
    assign ras_ok    = ras_reg >= RASW'(TRAS - 1);

    // A request accepted this cycle acts on the live fields; later stages
    // use the latched copy.
    assign acc_we    = accept ? req_we    : pend_we_reg;
    assign acc_row   = accept ? req_row   : pend_row_reg;
    assign acc_col   = accept ? req_col   : pend_col_reg;
    assign acc_wdata = accept ? req_wdata : pend_wdata_reg;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        ras_next        = ras_reg;
        act_next        = 1'b0;
        pr_next         = 1'b0;
        rd_next         = 1'b0;
        wr_next         = 1'b0;
        rd_req_next     = rd_req_reg;
        wr_req_next     = wr_req_reg;
        open_next       = open_reg;
        row_next        = row_reg;
        column_next     = column_reg;
        dq_next         = dq_reg;
        pend_we_next    = pend_we_reg;
        pend_row_next   = pend_row_reg;
        pend_col_next   = pend_col_reg;
        pend_wdata_next = pend_wdata_reg;
        start_act       = 1'b0;
        start_pre       = 1'b0;
        start_burst     = 1'b0;

        if (ras_reg < RASW'(TRAS))
            ras_next = ras_reg + RASW'(1);

        if (accept) begin
            pend_we_next    = req_we;
            pend_row_next   = req_row;
            pend_col_next   = req_col;
            pend_wdata_next = req_wdata;
        end

        case (state_reg)
            IDLE: begin
                if (accept)
                    start_act = 1'b1;
            end
            WAIT_RCD: begin
                if (cnt_reg == '0) start_burst = 1'b1;
                else               cnt_next = cnt_reg - CNTW'(1);
            end
            ACTIVE: begin
                if (accept) begin
                    if (req_row == row_reg) start_burst = 1'b1;
                    else if (ras_ok)        start_pre = 1'b1;
                    else                    state_next = WAIT_RAS;
                end
            end
            BURST: begin
                if (cnt_reg == '0) begin
                    rd_req_next = 1'b0;
                    wr_req_next = 1'b0;
`ifdef CLOSE_PAGE_EN
                    // Auto-precharge started with RDA/WRA; wait out tRP.
                    open_next  = 1'b0;
                    state_next = WAIT_RP;
                    cnt_next   = CNTW'(TRP - 1);
`else
                    state_next = ACTIVE;
`endif
                end else begin
                    cnt_next = cnt_reg - CNTW'(1);
                end
            end
            WAIT_RAS: begin
                if (ras_ok)
                    start_pre = 1'b1;
            end
            WAIT_RP: begin
                if (cnt_reg == '0) begin
`ifdef CLOSE_PAGE_EN
                    state_next = IDLE;
`else
                    start_act = 1'b1;
`endif
                end else begin
                    cnt_next = cnt_reg - CNTW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        if (start_act) begin
            act_next   = 1'b1;
            row_next   = acc_row;
            ras_next   = '0;
            open_next  = 1'b1;
            state_next = WAIT_RCD;
            cnt_next   = CNTW'(TRCD - 1);
        end
        if (start_pre) begin
            pr_next    = 1'b1;
            open_next  = 1'b0;
            state_next = WAIT_RP;
            cnt_next   = CNTW'(TRP - 1);
        end
        if (start_burst) begin
            rd_next     = !acc_we;
            wr_next     = acc_we;
            rd_req_next = !acc_we;
            wr_req_next = acc_we;
            column_next = acc_col;
            if (acc_we)
                dq_next = acc_wdata;
            state_next  = BURST;
            cnt_next    = CNTW'(TBURST - 1);
        end
    end

    // halt freezes every register, so a pulse already loaded simply waits
    // (masked below) until the first unhalted cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            ras_reg        <= '0;
            act_reg        <= 1'b0;
            pr_reg         <= 1'b0;
            rd_reg         <= 1'b0;
            wr_reg         <= 1'b0;
            rd_req_reg     <= 1'b0;
            wr_req_reg     <= 1'b0;
            open_reg       <= 1'b0;
            row_reg        <= '0;
            column_reg     <= '0;
            dq_reg         <= '0;
            pend_we_reg    <= 1'b0;
            pend_row_reg   <= '0;
            pend_col_reg   <= '0;
            pend_wdata_reg <= '0;
        end else if (!halt) begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            ras_reg        <= ras_next;
            act_reg        <= act_next;
            pr_reg         <= pr_next;
            rd_reg         <= rd_next;
            wr_reg         <= wr_next;
            rd_req_reg     <= rd_req_next;
            wr_req_reg     <= wr_req_next;
            open_reg       <= open_next;
            row_reg        <= row_next;
            column_reg     <= column_next;
            dq_reg         <= dq_next;
            pend_we_reg    <= pend_we_next;
            pend_row_reg   <= pend_row_next;
            pend_col_reg   <= pend_col_next;
            pend_wdata_reg <= pend_wdata_next;
        end
    end

    assign ACT = act_reg && !halt;
    assign PR  = pr_reg && !halt;
`ifdef CLOSE_PAGE_EN
    assign RD  = 1'b0;
    assign WR  = 1'b0;
    assign RDA = rd_reg && !halt;
    assign WRA = wr_reg && !halt;
`else
    assign RD  = rd_reg && !halt;
    assign WR  = wr_reg && !halt;
    assign RDA = 1'b0;
    assign WRA = 1'b0;
`endif
    assign done     = (state_reg == BURST) && (cnt_reg == '0) && !halt;
    assign row      = row_reg;
    assign column   = column_reg;
    assign dq       = dq_reg;
    assign rd_req   = rd_req_reg;
    assign wr_req   = wr_req_reg;
    assign row_open = open_reg;

endmodule

// File: tb/tb_dram_bank_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dram_bank_scheduler
//   Directed bench. Stimulus pushes the expected command/done events (cycle,
//   kind, argument) into a queue; a monitor on the falling edge pops one per
//   observed pulse and compares. Level checks are done inline.
// ---------------------------------------------------------------------------
module tb_dram_bank_scheduler;
    localparam int K_ACT = 1, K_PR = 2, K_RD = 3, K_WR = 4, K_RDA = 5, K_WRA = 6, K_DONE = 7;
`ifdef CLOSE_PAGE_EN
    localparam int K_RDX = K_RDA, K_WRX = K_WRA;
`else
    localparam int K_RDX = K_RD,  K_WRX = K_WR;
`endif

    logic       clk = 1'b0;
    logic       rst, halt, req_valid, req_ready, req_we;
    logic [6:0] req_row;
    logic [5:0] req_col;
    logic [7:0] req_wdata;
    logic       ACT, PR, RD, WR, RDA, WRA;
    logic [6:0] row;
    logic [5:0] column;
    logic [7:0] dq;
    logic       wr_req, rd_req, done, row_open;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int t;

    typedef struct {int cyc; int kind; int arg;} ev_t;
    ev_t exp_q[$];

    dram_bank_scheduler dut (
        .clk(clk), .rst(rst), .halt(halt),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
        .ACT(ACT), .PR(PR), .RD(RD), .WR(WR), .RDA(RDA), .WRA(WRA),
        .row(row), .column(column), .dq(dq),
        .wr_req(wr_req), .rd_req(rd_req), .done(done), .row_open(row_open)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d, required completion", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h required %0h", name, cyc, act, req);
        end else
            $display("ok   %s cycle %0d value %0h", name, cyc, act);
    endtask

    task automatic push(input int c, input int kind, input int arg);
        ev_t e;
        e.cyc = c; e.kind = kind; e.arg = arg;
        exp_q.push_back(e);
    endtask

    task automatic see(input int kind, input int arg);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cycle %0d kind %0d arg %0h, required none", cyc, kind, arg);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.kind != kind || e.arg != arg) begin
                errors++;
                $display("FAIL event got cycle %0d kind %0d arg %0h required cycle %0d kind %0d arg %0h",
                         cyc, kind, arg, e.cyc, e.kind, e.arg);
            end else
                $display("ok   event cycle %0d kind %0d arg %0h", cyc, kind, arg);
        end
    endtask

    // Monitor: every observed pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event kind %0d at cycle %0d, seen none by cycle %0d",
                         exp_q[0].kind, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (ACT)  see(K_ACT, int'(row));
            if (PR)   see(K_PR, 0);
            if (RD)   see(K_RD, int'(column) << 8);
            if (WR)   see(K_WR, (int'(column) << 8) | int'(dq));
            if (RDA)  see(K_RDA, int'(column) << 8);
            if (WRA)  see(K_WRA, (int'(column) << 8) | int'(dq));
            if (done) see(K_DONE, 0);
            checks++;
            if (int'(ACT) + int'(PR) + int'(RD) + int'(WR) + int'(RDA) + int'(WRA) > 1) begin
                errors++;
                $display("FAIL one_command cycle %0d got %b required at most one",
                         cyc, {ACT, PR, RD, WR, RDA, WRA});
            end
        end
    end

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request in the current cycle for one cycle.
    task automatic issue(input bit we, input int r, input int c, input int d);
        req_valid = 1'b1;
        req_we    = we;
        req_row   = 7'(r);
        req_col   = 6'(c);
        req_wdata = 8'(d);
        chk("req_ready_at_accept", req_ready, 1);
        at_cycle(cyc + 1);
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_row = '0; req_col = '0; req_wdata = '0;
        at_cycle(3);
        rst = 1'b0;
        chk("reset_outputs", {ACT, PR, RD, WR, RDA, WRA, done, rd_req, wr_req, row_open, row, column, dq}, 0);
        chk("reset_ready", req_ready, 1);

        // Test 1: write row 5 col 1 data 01 from IDLE
        t = 4;
        at_cycle(t);
        push(t + 1, K_ACT, 5);
        push(t + 5, K_WRX, 'h101);
        push(t + 8, K_DONE, 0);
        issue(1, 5, 1, 'h01);
        at_cycle(t + 5);
        chk("t1_wr_req_first", wr_req, 1);
        chk("t1_column", column, 1);
        chk("t1_dq", dq, 'h01);
        at_cycle(t + 8);
        chk("t1_wr_req_last", wr_req, 1);
        at_cycle(t + 9);
        chk("t1_wr_req_after", wr_req, 0);
`ifndef CLOSE_PAGE_EN
        chk("t1_row_open", row_open, 1);
        chk("t1_ready_after", req_ready, 1);

        // Test 2: row hit read
        t = t + 9;
        push(t + 1, K_RD, 'h200);
        push(t + 4, K_DONE, 0);
        issue(0, 5, 2, 0);
        chk("t2_rd_req_first", rd_req, 1);
        at_cycle(t + 4);
        chk("t2_rd_req_last", rd_req, 1);
        at_cycle(t + 5);
        chk("t2_rd_req_after", rd_req, 0);

        // Test 3: row miss, tRAS already met
        t = t + 5;
        push(t + 1, K_PR, 0);
        push(t + 5, K_ACT, 9);
        push(t + 9, K_RD, 'h300);
        push(t + 12, K_DONE, 0);
        issue(0, 9, 3, 0);
        chk("t3_busy", req_ready, 0);
        at_cycle(t + 2);
        chk("t3_row_closed", row_open, 0);
        at_cycle(t + 6);
        chk("t3_row_reopened", row_open, 1);

        // Row miss 8 cycles after ACT: PR must wait until ACT+TRAS
        t = t + 13;
        at_cycle(t);
        push(t + 2, K_PR, 0);
        push(t + 6, K_ACT, 3);
        push(t + 10, K_WR, 'h7A5);
        push(t + 13, K_DONE, 0);
        issue(1, 3, 7, 'hA5);
        at_cycle(t + 14);
        chk("ras_ready_after", req_ready, 1);
        chk("ras_row", row, 3);
`else
        chk("t1_row_open_cp", row_open, 0);
        chk("t1_busy_rp_cp", req_ready, 0);

        // Close page: the second request to the same row needs a new ACT
        t = t + 13;
        at_cycle(t);
        push(t + 1, K_ACT, 5);
        push(t + 5, K_RDA, 'h200);
        push(t + 8, K_DONE, 0);
        issue(0, 5, 2, 0);
        at_cycle(t + 9);
        chk("t2_row_open_cp", row_open, 0);
        at_cycle(t + 13);
        chk("t2_ready_cp", req_ready, 1);
`endif

        // Test 4: test 1 with halt in cycles 2-4 and again mid-burst
        rst = 1'b1;
        at_cycle(cyc + 2);
        rst = 1'b0;
        t = cyc;
        push(t + 1, K_ACT, 5);
        push(t + 8, K_WRX, 'h101);
        push(t + 12, K_DONE, 0);
        issue(1, 5, 1, 'h01);
        at_cycle(t + 2);
        halt = 1'b1;
        chk("t4_halt_not_ready", req_ready, 0);
        at_cycle(t + 5);
        halt = 1'b0;
        at_cycle(t + 8);
        chk("t4_wr_req_start", wr_req, 1);
        at_cycle(t + 9);
        halt = 1'b1;
        chk("t4_wr_req_held", wr_req, 1);
        at_cycle(t + 10);
        halt = 1'b0;
        at_cycle(t + 12);
        chk("t4_wr_req_last", wr_req, 1);
        at_cycle(t + 13);
        chk("t4_wr_req_after", wr_req, 0);

        // Test 5: reset mid-access, then the next request starts with ACT
        at_cycle(t + 17);
        rst = 1'b1;
        at_cycle(cyc + 2);
        rst = 1'b0;
        t = cyc;
        push(t + 1, K_ACT, 5);
        push(t + 5, K_WRX, 'h101);
        issue(1, 5, 1, 'h01);
        at_cycle(t + 6);
        rst = 1'b1;
        at_cycle(t + 7);
        rst = 1'b0;
        chk("t5_outputs_cleared", {ACT, PR, RD, WR, RDA, WRA, done, rd_req, wr_req, row_open, row, column, dq}, 0);
        chk("t5_ready", req_ready, 1);
        push(t + 8, K_ACT, 5);
        push(t + 12, K_RDX, 'h200);
        push(t + 15, K_DONE, 0);
        issue(0, 5, 2, 0);
        at_cycle(t + 20);

        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
